psw_ctrl: RTL

- Owns the XM23 program status word. It is the consumer side of the ALU's psw_out/psw_msk interface and the producer of the ALU's carry_in.
- Applies masked flag updates from execute and SETCC/CLRCC bit writes.
- Saves and restores the PSW on exception entry and RETI through an internal LIFO.
- Sits beside the execute stage; the pipeline stalls while busy is high.

---
 rtl/psw_ctrl_pkg.sv | 28 ++
 rtl/psw_ctrl_if.sv | 48 ++++
 rtl/psw_ctrl_stack.sv | 56 +++++
 rtl/psw_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/psw_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// xm23_psw_pkg
// Shared definitions for the XM23 program status word controller.
//   - Bit positions of every PSW field.
//   - PSW_WRITABLE_MSK: bits that hold state. Every other bit reads 0.
//   - psw_state_e: states of the exception entry/return sequencer.
// ---------------------------------------------------------------------------
package xm23_psw_pkg;

    localparam int PSW_C            = 0;
    localparam int PSW_Z            = 1;
    localparam int PSW_N            = 2;
    localparam int PSW_SLP          = 3;
    localparam int PSW_V            = 4;
    localparam int PSW_CUR_PRI_LSB  = 5;
    localparam int PSW_FLT          = 8;
    localparam int PSW_PREV_PRI_LSB = 13;

    localparam logic [15:0] PSW_WRITABLE_MSK = 16'hE1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        LOAD = 2'd2,
        POP  = 2'd3
    } psw_state_e;

endpackage

// File: rtl/psw_ctrl_if.sv
// ---------------------------------------------------------------------------
// psw_ctrl_if
// Bundles the PSW controller's pipeline-facing signals.
//   master : execute stage / exception logic (drives requests and updates)
//   slave  : psw_ctrl (returns PSW, acks, busy, fault, stack depth)
// Signals:
//   stall, alu_valid, alu_psw_out[15:0], alu_psw_msk[15:0]
//   cc_set, cc_clr, cc_bits[4:0]
//   exc_req, exc_pri[2:0], ret_req      -> requests (level, held until ack)
//   exc_ack, ret_ack                    -> one-cycle acknowledge pulses
//   busy, psw[15:0], carry_out, fault, depth[$clog2(DEPTH+1)-1:0]
// ---------------------------------------------------------------------------
interface psw_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic          stall;
    logic          alu_valid;
    logic [15:0]   alu_psw_out;
    logic [15:0]   alu_psw_msk;
    logic          cc_set;
    logic          cc_clr;
    logic [4:0]    cc_bits;
    logic          exc_req;
    logic [2:0]    exc_pri;
    logic          ret_req;
    logic          exc_ack;
    logic          ret_ack;
    logic          busy;
    logic [15:0]   psw;
    logic          carry_out;
    logic          fault;
    logic [DW-1:0] depth;

    modport master (
        output stall, alu_valid, alu_psw_out, alu_psw_msk,
               cc_set, cc_clr, cc_bits, exc_req, exc_pri, ret_req,
        input  exc_ack, ret_ack, busy, psw, carry_out, fault, depth
    );

    modport slave (
        input  stall, alu_valid, alu_psw_out, alu_psw_msk,
               cc_set, cc_clr, cc_bits, exc_req, exc_pri, ret_req,
        output exc_ack, ret_ack, busy, psw, carry_out, fault, depth
    );

endinterface

// File: rtl/psw_ctrl_stack.sv
// ---------------------------------------------------------------------------
// psw_stack
// Small LIFO holding saved PSW words across nested exceptions.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears occupancy)
//   push, din    write din on top; ignored when full
//   pop          drop the top entry; ignored when empty
//   dout         current top entry (valid only when !empty)
//   depth        number of occupied entries (0..DEPTH)
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module psw_stack #(
    parameter  int DEPTH = 4,
    parameter  int W     = 16,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    // Storage is rounded up to a power of two so the slot index can be a
    // plain truncation of the occupancy count.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [DW-1:0] depth_q;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    assign dout  = mem[AW'(depth_q - DW'(1))];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else if (push && !full) begin
            depth_q <= depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_q <= depth_q - DW'(1);
        end
    end

    // Stored words need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[AW'(depth_q)] <= din;
        end
    end

endmodule

// File: rtl/psw_ctrl.sv
// ---------------------------------------------------------------------------
// psw_ctrl
// Owns the XM23 program status word.
//   - Applies masked ALU flag updates and SETCC/CLRCC writes while idle.
//   - Saves the PSW on exception entry and restores it on RETI.
//   - Drives the ALU carry input from the registered C flag.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     psw_ctrl_if.slave (stall, ALU update, CC ops, exc/ret
//           handshakes, busy, psw, carry_out, fault, depth)
// Parameters:
//   DEPTH      nested save entries (1..8)
//   RESET_PSW  PSW after reset
// Build option:
//   PSW_STACK_EN  defined  : DEPTH-entry save LIFO (psw_stack)
//                 undefined: single save register, effective depth 1
// Timing: exc_ack rises 2 cycles after an entry is accepted, ret_ack 1
// cycle after a return is accepted; both coincide with the new PSW.
// ---------------------------------------------------------------------------
module psw_ctrl
    import xm23_psw_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] RESET_PSW = 16'h00E0
) (
    input  logic     clk,
    input  logic     rst_n,
    psw_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);

    psw_state_e    state;
    logic [15:0]   psw_q;
    logic          fault_q;
    logic          exc_ack_q;
    logic          ret_ack_q;

    logic          stk_push;
    logic          stk_pop;
    logic [15:0]   stk_dout;
    logic [DW-1:0] stk_depth;
    logic          stk_full;
    logic          stk_empty;

    // Masked ALU write; non-writable bits are never touched.
    function automatic logic [15:0] alu_apply(input logic [15:0] cur,
                                              input logic [15:0] val,
                                              input logic [15:0] msk,
                                              input logic        vld);
        logic [15:0] m;
        m = vld ? (msk & PSW_WRITABLE_MSK) : 16'h0000;
        return (cur & ~m) | (val & m);
    endfunction

    // SETCC/CLRCC on the low five flags; set wins when both are requested.
    function automatic logic [15:0] cc_apply(input logic [15:0] cur,
                                             input logic        set,
                                             input logic        clr,
                                             input logic [4:0]  bits);
        logic [15:0] r;
        r = cur;
        if (set) begin
            r[4:0] = r[4:0] | bits;
        end else if (clr) begin
            r[4:0] = r[4:0] & ~bits;
        end
        return r;
    endfunction

    assign stk_push = (state == PUSH) && !stk_full;
    assign stk_pop  = (state == POP)  && !stk_empty;

`ifdef PSW_STACK_EN
    psw_stack #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (psw_q),
        .dout  (stk_dout),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );
`else
    logic [15:0] save_q;
    logic        save_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            save_vld <= 1'b0;
        end else if (stk_push) begin
            save_vld <= 1'b1;
        end else if (stk_pop) begin
            save_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (stk_push) begin
            save_q <= psw_q;
        end
    end

    assign stk_dout  = save_q;
    assign stk_full  = save_vld;
    assign stk_empty = !save_vld;
    assign stk_depth = DW'(save_vld);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            psw_q     <= RESET_PSW;
            fault_q   <= 1'b0;
            exc_ack_q <= 1'b0;
            ret_ack_q <= 1'b0;
        end else begin
            exc_ack_q <= 1'b0;
            ret_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    // ALU result first, then the CC op on top of it.
                    if (!bus.stall) begin
                        psw_q <= cc_apply(alu_apply(psw_q, bus.alu_psw_out,
                                                    bus.alu_psw_msk, bus.alu_valid),
                                          bus.cc_set, bus.cc_clr, bus.cc_bits);
                    end
                    if (bus.ret_req) begin
                        state <= POP;
                    end else if (bus.exc_req) begin
                        state <= PUSH;
                    end
                end
                PUSH: begin
                    // On overflow nothing is saved, but entry still proceeds.
                    if (stk_full) begin
                        fault_q        <= 1'b1;
                        psw_q[PSW_FLT] <= 1'b1;
                    end
                    state <= LOAD;
                end
                LOAD: begin
                    psw_q[PSW_PREV_PRI_LSB +: 3] <= psw_q[PSW_CUR_PRI_LSB +: 3];
                    psw_q[PSW_CUR_PRI_LSB +: 3]  <= bus.exc_pri;
                    psw_q[PSW_SLP]               <= 1'b0;
                    exc_ack_q                    <= 1'b1;
                    state                        <= IDLE;
                end
                POP: begin
                    if (stk_empty) begin
                        fault_q <= 1'b1;
                    end else begin
                        psw_q <= stk_dout & PSW_WRITABLE_MSK;
                    end
                    ret_ack_q <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.psw       = psw_q;
    assign bus.carry_out = psw_q[PSW_C];
    assign bus.fault     = fault_q;
    assign bus.depth     = stk_depth;
    assign bus.busy      = (state != IDLE);
    assign bus.exc_ack   = exc_ack_q;
    assign bus.ret_ack   = ret_ack_q;

endmodule
